// File: rtl/ring_johnson_pkg.sv
// ============================================================================
// ring_johnson_pkg : FSM encodings and Johnson-code helpers for the decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package ring_johnson_pkg;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_LOCKING  = 2'd1,
    S_LOCKED   = 2'd2,
    S_ERROR    = 2'd3
  } jpd_state_t;

  // Low k bits set for the filling half, upper bits set for the draining half.
  function automatic int johnson_code(input int k, input int n);
    int full;
    full = (1 << n) - 1;
    if (k <= n) return (1 << k) - 1;
    return full & ~((1 << (k - n)) - 1);
  endfunction

  function automatic int johnson_succ(input int idx, input int n);
    return (idx + 1) % (2 * n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_code_decode.sv
// ============================================================================
// johnson_code_decode : combinational Johnson code -> legal/index/one-hot
// Rev 1.0
// ============================================================================
`default_nettype none

module johnson_code_decode
  import ring_johnson_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]               code_in,
  output logic                       legal,
  output logic [$clog2(2*N)-1:0]     idx,
  output logic [2*N-1:0]             onehot
);

  localparam int IDX_W = $clog2(2 * N);

  for (genvar k = 0; k < 2 * N; k++) begin : g_state_match
    localparam int          CODE_I = johnson_code(k, N);
    localparam logic [N-1:0] CODE  = CODE_I[N-1:0];
    assign onehot[k] = (code_in == CODE);
  end

  // Legal codes are distinct, so at most one onehot bit can be set.
  always_comb begin
    legal = |onehot;
    idx   = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (onehot[k]) idx = IDX_W'(k);
    end
  end

endmodule

`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
// ============================================================================
// johnson_phase_decoder : Johnson count -> phase, sequence check, lock status
// Optional error counter enabled by defining JPD_ERR_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module johnson_phase_decoder
  import ring_johnson_pkg::*;
#(
  parameter int N         = 3,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               code_in,
  input  logic                       code_vld,
  output logic [2*N-1:0]             phase_oh,
  output logic [$clog2(2*N)-1:0]     phase_idx,
  output logic                       phase_stb,
  output logic                       locked,
  output logic                       err_pulse
`ifdef JPD_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]       err_cnt
`endif
);

  localparam int IDX_W = $clog2(2 * N);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);

  if (N < 2 || LOCK_CNT < 1 || ERR_CNT_W < 1) begin : g_param_check
    $error("johnson_phase_decoder: illegal parameter set");
  end

  jpd_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
  logic [2*N-1:0]         oh_nxt;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   stb_nxt, err_nxt;

  logic                   dec_legal;
  logic [IDX_W-1:0]       dec_idx;
  logic [2*N-1:0]         dec_oh;
  logic                   is_succ, is_stall;

  johnson_code_decode #(.N(N)) u_decode (
    .code_in (code_in),
    .legal   (dec_legal),
    .idx     (dec_idx),
    .onehot  (dec_oh)
  );

  // phase_idx only ever holds the last legal index, so it doubles as history.
  assign is_succ  = (int'(dec_idx) == johnson_succ(int'(phase_idx), N));
  assign is_stall = (dec_idx == phase_idx);
  assign cnt_inc  = cnt + 1'b1;
  assign locked   = (state == S_LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_UNLOCKED;
      cnt       <= '0;
      phase_oh  <= '0;
      phase_idx <= '0;
      phase_stb <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phase_oh  <= oh_nxt;
      phase_idx <= idx_nxt;
      phase_stb <= stb_nxt;
      err_pulse <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    oh_nxt    = phase_oh;
    idx_nxt   = phase_idx;
    stb_nxt   = 1'b0;
    err_nxt   = 1'b0;

    // ERROR is left after exactly one cycle whether or not a sample arrives.
    if (state == S_ERROR) begin
      state_nxt = S_UNLOCKED;
      cnt_nxt   = '0;
    end

    if (code_vld) begin
      if (dec_legal) begin
        oh_nxt  = dec_oh;
        idx_nxt = dec_idx;
        stb_nxt = 1'b1;
      end else begin
        oh_nxt  = '0;
      end

      unique case (state)
        S_UNLOCKED: begin
          if (dec_legal) begin
            state_nxt = S_LOCKING;
            cnt_nxt   = '0;
          end else begin
            err_nxt   = 1'b1;
          end
        end
        S_LOCKING: begin
          if (!dec_legal) begin
            state_nxt = S_UNLOCKED;
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
          end else if (is_succ) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == LOCK_V) state_nxt = S_LOCKED;
          end else if (!is_stall) begin
            cnt_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (!dec_legal || !(is_succ || is_stall)) begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end
        end
        S_ERROR: begin
          // Decoded above, deliberately not sequence-checked.
        end
        default: begin
          state_nxt = S_UNLOCKED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef JPD_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_nxt && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
// ============================================================================
// tb_johnson_phase_decoder : directed scoreboard bench, N=3, LOCK_CNT=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_johnson_phase_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] code_in;
  logic       code_vld;
  logic [5:0] phase_oh;
  logic [2:0] phase_idx;
  logic       phase_stb;
  logic       locked;
  logic       err_pulse;
`ifdef JPD_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  johnson_phase_decoder #(.N(3), .LOCK_CNT(4), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_vld  (code_vld),
    .phase_oh  (phase_oh),
    .phase_idx (phase_idx),
    .phase_stb (phase_stb),
    .locked    (locked),
    .err_pulse (err_pulse)
`ifdef JPD_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] oh;
    logic [2:0] idx;
    logic       stb;
    logic       lk;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s: scoreboard empty observed 1 expected 0", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".oh"},  32'(phase_oh),  32'(e.oh));
      chk({tag, ".idx"}, 32'(phase_idx), 32'(e.idx));
      chk({tag, ".stb"}, 32'(phase_stb), 32'(e.stb));
      chk({tag, ".lk"},  32'(locked),    32'(e.lk));
      chk({tag, ".err"}, 32'(err_pulse), 32'(e.err));
    end
  endtask

  task automatic step(input string tag, input logic vld, input logic [2:0] code,
                      input logic [5:0] oh, input int idx, input logic stb,
                      input logic lk, input logic err);
    exp_t e;
    e.oh  = oh;
    e.idx = 3'(idx);
    e.stb = stb;
    e.lk  = lk;
    e.err = err;
    sb.push_back(e);
    code_vld = vld;
    code_in  = code;
    @(posedge clk);
    #1;
    compare_front(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    code_vld = 1'b0;
    code_in  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('0);
    compare_front("reset");
`ifdef JPD_ERR_CNT_EN
    chk("reset.err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk) rst = 1'b1;

    // Lock-up from 000 through 110.
    step("lk0", 1, 3'b000, 6'h01, 0, 1, 0, 0);
    step("lk1", 1, 3'b001, 6'h02, 1, 1, 0, 0);
    step("lk2", 1, 3'b011, 6'h04, 2, 1, 0, 0);
    step("lk3", 1, 3'b111, 6'h08, 3, 1, 0, 0);
    step("lk4", 1, 3'b110, 6'h10, 4, 1, 1, 0);

    // Wrap 100 -> 000, then idle hold.
    step("wrap5", 1, 3'b100, 6'h20, 5, 1, 1, 0);
    step("wrap0", 1, 3'b000, 6'h01, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step("idle", 0, 3'b101, 6'h01, 0, 0, 1, 0);

    // Stall on 111 keeps lock and strobes.
    step("st1", 1, 3'b001, 6'h02, 1, 1, 1, 0);
    step("st2", 1, 3'b011, 6'h04, 2, 1, 1, 0);
    step("st3", 1, 3'b111, 6'h08, 3, 1, 1, 0);
    step("stall", 1, 3'b111, 6'h08, 3, 1, 1, 0);

    // Skip 011 -> 110 while locked.
    step("sk4", 1, 3'b110, 6'h10, 4, 1, 1, 0);
    step("sk5", 1, 3'b100, 6'h20, 5, 1, 1, 0);
    step("sk0", 1, 3'b000, 6'h01, 0, 1, 1, 0);
    step("sk1", 1, 3'b001, 6'h02, 1, 1, 1, 0);
    step("sk2", 1, 3'b011, 6'h04, 2, 1, 1, 0);
    step("skip", 1, 3'b110, 6'h10, 4, 1, 0, 1);
    step("errcyc", 1, 3'b100, 6'h20, 5, 1, 0, 0);

    // Relock, then illegal 010.
    step("rl0", 1, 3'b000, 6'h01, 0, 1, 0, 0);
    step("rl1", 1, 3'b001, 6'h02, 1, 1, 0, 0);
    step("rl2", 1, 3'b011, 6'h04, 2, 1, 0, 0);
    step("rl3", 1, 3'b111, 6'h08, 3, 1, 0, 0);
    step("rl4", 1, 3'b110, 6'h10, 4, 1, 1, 0);
    step("ill", 1, 3'b010, 6'h00, 4, 0, 0, 1);
    step("ill_idle", 0, 3'b000, 6'h00, 4, 0, 0, 0);
    step("ill_unl", 1, 3'b010, 6'h00, 4, 0, 0, 1);

    // Illegal while LOCKING drops to UNLOCKED.
    step("lg0", 1, 3'b000, 6'h01, 0, 1, 0, 0);
    step("lg1", 1, 3'b001, 6'h02, 1, 1, 0, 0);
    step("lg_ill", 1, 3'b101, 6'h00, 1, 0, 0, 1);

    // Rebase on 000 -> 011 restarts the successor count.
    step("rb0", 1, 3'b000, 6'h01, 0, 1, 0, 0);
    step("rb2", 1, 3'b011, 6'h04, 2, 1, 0, 0);
    step("rb3", 1, 3'b111, 6'h08, 3, 1, 0, 0);
    step("rb4", 1, 3'b110, 6'h10, 4, 1, 0, 0);
    step("rb5", 1, 3'b100, 6'h20, 5, 1, 0, 0);
    step("rb0w", 1, 3'b000, 6'h01, 0, 1, 1, 0);
`ifdef JPD_ERR_CNT_EN
    chk("err_cnt4", 32'(err_cnt), 32'd4);
`endif

    // Asynchronous reset mid-cycle while locked.
    #2;
    rst = 1'b0;
    #1;
    sb.push_back('0);
    compare_front("arst");
`ifdef JPD_ERR_CNT_EN
    chk("arst.err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk) rst = 1'b1;

    // From UNLOCKED, 001 must start LOCKING rather than count as a skip.
    step("pr1", 1, 3'b001, 6'h02, 1, 1, 0, 0);
    step("pr2", 1, 3'b011, 6'h04, 2, 1, 0, 0);
    step("pr3", 1, 3'b111, 6'h08, 3, 1, 0, 0);
    step("pr4", 1, 3'b110, 6'h10, 4, 1, 0, 0);
    step("pr5", 1, 3'b100, 6'h20, 5, 1, 1, 0);

`ifdef JPD_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      code_vld = 1'b1;
      code_in  = 3'b010;
      @(posedge clk);
    end
    #1;
    chk("err_sat", 32'(err_cnt), 32'd255);
`endif

    code_vld = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
